// File: rtl/rsa_pkg.sv
// Shared types and default sizes for the RSA modular-exponentiation datapath.
package rsa_pkg;

    // Default operand width and exponent bit-index width (2^LOGK >= K).
    localparam int unsigned K    = 192;
    localparam int unsigned LOGK = 8;

    // Main square-and-multiply sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CONV_B,
        CONV_1,
        SQR,
        MUL,
        STEP,
        CONV_OUT,
        FINISH
    } main_state_t;

    // Multiply-request handshake phases. ISSUE doubles as the ready state.
    typedef enum logic [1:0] {
        ISSUE,
        WAIT_LO,
        WAIT_HI
    } mm_phase_t;

endpackage : rsa_pkg

// File: rtl/mod_exp_ctrl_mm_req.sv
// Multiply-request handshake engine: launches one Montgomery multiply per go
// and returns its result once the multiplier's done level is seen fresh.
module mm_req #(
    parameter int unsigned K = rsa_pkg::K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [K-1:0] x,
    input  logic [K-1:0] y,
    output logic [K-1:0] mm_x,
    output logic [K-1:0] mm_y,
    output logic         mm_start,
    input  logic [K-1:0] mm_z,
    input  logic         mm_done,
    output logic [K-1:0] res,
    output logic         res_valid
);

    import rsa_pkg::*;

    mm_phase_t    r_phase;
    mm_phase_t    w_phase_nxt;
    logic         w_accept;
    logic         w_capture;
    logic [K-1:0] r_mm_x;
    logic [K-1:0] r_mm_y;
    logic         r_mm_start;
    logic [K-1:0] r_res;
    logic         r_res_valid;

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= ISSUE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Next phase: accept a request, wait out the stale done level, then catch the fresh one.
    always_comb begin
        w_phase_nxt = r_phase;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_phase)
            ISSUE: begin
                if (go) begin
                    w_accept    = 1'b1;
                    w_phase_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!mm_done) begin
                    w_phase_nxt = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (mm_done) begin
                    w_capture   = 1'b1;
                    w_phase_nxt = ISSUE;
                end
            end
            default: begin
                w_phase_nxt = ISSUE;
            end
        endcase
    end

    // Operand, start-pulse and result registers; operands only move on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mm_x      <= '0;
            r_mm_y      <= '0;
            r_mm_start  <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_mm_start  <= w_accept;
            r_res_valid <= w_capture;
            if (w_accept) begin
                r_mm_x <= x;
                r_mm_y <= y;
            end
            if (w_capture) begin
                r_res <= mm_z;
            end
        end
    end

    assign mm_x      = r_mm_x;
    assign mm_y      = r_mm_y;
    assign mm_start  = r_mm_start;
    assign res       = r_res;
    assign res_valid = r_res_valid;

endmodule : mm_req

// File: rtl/mod_exp_ctrl.sv
// Montgomery modular-exponentiation sequencer: base^exp mod M by MSB-first
// square-and-multiply, driving an external bit-serial Montgomery multiplier.
module mod_exp_ctrl #(
    parameter int unsigned     K        = rsa_pkg::K,
    parameter int unsigned     LOGK     = rsa_pkg::LOGK,
    parameter logic [K-1:0]    M        = K'(192'hfffffffffffffffffffffffffffffffeffffffffffffffff),
    parameter logic [K-1:0]    R2_MOD_M = K'(192'h000000000000000100000000000000020000000000000001)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [K-1:0] base,
    input  logic [K-1:0] exp,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] result,
    output logic [K-1:0] mm_x,
    output logic [K-1:0] mm_y,
    output logic         mm_start,
    input  logic [K-1:0] mm_z,
    input  logic         mm_done
);

    import rsa_pkg::*;

    localparam logic [K-1:0] ONE = K'(1);

    // Elaboration-time sanity checks on the parameter set.
    if (M[0] == 1'b0) begin : g_even_modulus
        $error("mod_exp_ctrl: modulus M must be odd");
    end
    if ((64'd1 << LOGK) < 64'(K)) begin : g_short_index
        $error("mod_exp_ctrl: LOGK too small for K");
    end

    main_state_t     r_state;
    main_state_t     w_state_nxt;
    logic [K-1:0]    r_base;
    logic [K-1:0]    r_exp;
    logic [K-1:0]    r_bm;
    logic [K-1:0]    r_acc;
    logic [K-1:0]    r_result;
    logic [LOGK-1:0] r_idx;
    logic            r_issued;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_mult_state;
    logic            w_go;
    logic            w_bit;
    logic [K-1:0]    w_x;
    logic [K-1:0]    w_y;
    logic [K-1:0]    w_res;
    logic            w_res_valid;

    assign w_bit = r_exp[r_idx];
    assign w_go  = w_mult_state & ~r_issued;

    // Main state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state multiplier operand selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_mult_state = 1'b0;
        w_x          = '0;
        w_y          = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CONV_B;
                end
            end
            CONV_B: begin
                w_mult_state = 1'b1;
                w_x          = r_base;
                w_y          = R2_MOD_M;
                if (w_res_valid) begin
                    w_state_nxt = CONV_1;
                end
            end
            CONV_1: begin
                w_mult_state = 1'b1;
                w_x          = ONE;
                w_y          = R2_MOD_M;
                if (w_res_valid) begin
                    w_state_nxt = SQR;
                end
            end
            SQR: begin
                w_mult_state = 1'b1;
                w_x          = r_acc;
                w_y          = r_acc;
                if (w_res_valid) begin
                    w_state_nxt = w_bit ? MUL : STEP;
                end
            end
            MUL: begin
                w_mult_state = 1'b1;
                w_x          = r_acc;
                w_y          = r_bm;
                if (w_res_valid) begin
                    w_state_nxt = STEP;
                end
            end
            STEP: begin
                w_state_nxt = (r_idx == '0) ? CONV_OUT : SQR;
            end
            CONV_OUT: begin
                w_mult_state = 1'b1;
                w_x          = r_acc;
                w_y          = ONE;
                if (w_res_valid) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, bit index, Montgomery accumulators and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base   <= '0;
            r_exp    <= '0;
            r_bm     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_issued <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE) && (w_state_nxt != FINISH);
            r_done <= (w_state_nxt == FINISH);
            if (w_accept) begin
                r_base <= base;
                r_exp  <= exp;
                r_idx  <= LOGK'(K - 1);
            end
            if (w_go) begin
                r_issued <= 1'b1;
            end else if (w_res_valid) begin
                r_issued <= 1'b0;
            end
            if (w_res_valid) begin
                case (r_state)
                    CONV_B:           r_bm     <= w_res;
                    CONV_1, SQR, MUL: r_acc    <= w_res;
                    CONV_OUT:         r_result <= w_res;
                    default:          ;
                endcase
            end
            if ((r_state == STEP) && (r_idx != '0)) begin
                r_idx <= r_idx - LOGK'(1);
            end
        end
    end

    // One multiply per go; the engine owns the multiplier handshake.
    mm_req #(
        .K (K)
    ) u_mm_req (
        .clk       (clk),
        .rst       (rst),
        .go        (w_go),
        .x         (w_x),
        .y         (w_y),
        .mm_x      (mm_x),
        .mm_y      (mm_y),
        .mm_start  (mm_start),
        .mm_z      (mm_z),
        .mm_done   (mm_done),
        .res       (w_res),
        .res_valid (w_res_valid)
    );

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule : mod_exp_ctrl

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with K=8, M=239 and a behavioural Montgomery multiplier.
module tb_mod_exp_ctrl;

    localparam int unsigned K       = 8;
    localparam int unsigned LOGK    = 3;
    localparam logic [K-1:0] MODV   = 8'd239;
    localparam logic [K-1:0] R2V    = 8'd50;
    localparam int unsigned RINV    = 225;    // 256^-1 mod 239
    localparam logic [K-1:0] GARB   = 8'hA5;  // presented on mm_z while a multiply is in flight
    localparam int TIMEOUT          = 3000;

    typedef struct {
        logic [K-1:0] result;
        int           starts;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_item;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [K-1:0] base_i;
    logic [K-1:0] exp_i;
    logic         busy;
    logic         done;
    logic [K-1:0] result;
    logic [K-1:0] mm_x;
    logic [K-1:0] mm_y;
    logic         mm_start;
    logic [K-1:0] mm_z;
    logic         mm_done;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [K-1:0] last_result = '0;

    // multiplier model knobs and state
    int           hold_extra = 0;
    bit           rand_lat = 1'b0;
    logic [K-1:0] mdl_x, mdl_y;
    int           mdl_hold, mdl_cnt;
    bit           mdl_busy;

    // monitor state
    bit           prev_start, prev_done, have_ops;
    logic [K-1:0] saved_x, saved_y;

    mod_exp_ctrl #(
        .K        (K),
        .LOGK     (LOGK),
        .M        (MODV),
        .R2_MOD_M (R2V)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base_i),
        .exp      (exp_i),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .mm_x     (mm_x),
        .mm_y     (mm_y),
        .mm_start (mm_start),
        .mm_z     (mm_z),
        .mm_done  (mm_done)
    );

    always #5 clk = ~clk;

    function automatic logic [K-1:0] mont(input logic [K-1:0] a, input logic [K-1:0] b);
        int unsigned p;
        p = (32'(a) * 32'(b)) % 239;
        p = (p * RINV) % 239;
        return K'(p);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Montgomery multiplier model: optional stale-done hold and random latency.
    always @(posedge clk) begin
        if (rst) begin
            mm_done  <= 1'b0;
            mm_z     <= '0;
            mdl_busy <= 1'b0;
            mdl_hold <= 0;
            mdl_cnt  <= 0;
            mdl_x    <= '0;
            mdl_y    <= '0;
        end else if (mm_start) begin
            mdl_x    <= mm_x;
            mdl_y    <= mm_y;
            mdl_busy <= 1'b1;
            mdl_cnt  <= 1 + (rand_lat ? int'($urandom_range(0, 5)) : 0);
            if (hold_extra == 0) begin
                mm_done  <= 1'b0;
                mm_z     <= GARB;
                mdl_hold <= 0;
            end else begin
                mdl_hold <= hold_extra;
            end
        end else if (mdl_busy) begin
            if (mdl_hold != 0) begin
                mdl_hold <= mdl_hold - 1;
                if (mdl_hold == 1) begin
                    mm_done <= 1'b0;
                    mm_z    <= GARB;
                end
            end else if (mdl_cnt > 1) begin
                mdl_cnt <= mdl_cnt - 1;
            end else begin
                mm_done  <= 1'b1;
                mm_z     <= mont(mdl_x, mdl_y);
                mdl_busy <= 1'b0;
            end
        end
    end

    // Monitor: handshake rules, operand stability and scoreboard compare on done.
    always @(negedge clk) begin
        if (rst) begin
            start_cnt  = 0;
            prev_start = 1'b0;
            prev_done  = 1'b0;
            have_ops   = 1'b0;
        end else begin
            if (mm_start) begin
                start_cnt++;
                check("mm_start_back_to_back", 32'(prev_start), 32'd0);
                saved_x  = mm_x;
                saved_y  = mm_y;
                have_ops = 1'b1;
            end else if (have_ops) begin
                check("operand_x_stable", 32'(mm_x), 32'(saved_x));
                check("operand_y_stable", 32'(mm_y), 32'(saved_y));
            end
            if (done) begin
                check("busy_low_at_done", 32'(busy), 32'd0);
                check("done_single_cycle", 32'(prev_done), 32'd0);
                check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_item = exp_q.pop_front();
                    check("result", 32'(result), 32'(mon_item.result));
                    check("mm_start_count", 32'(start_cnt), 32'(mon_item.starts));
                end
                start_cnt = 0;
            end
            prev_start = mm_start;
            prev_done  = done;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_mm_start"}, 32'(mm_start), 32'd0);
        check({tag, "_mm_x"}, 32'(mm_x), 32'd0);
        check({tag, "_mm_y"}, 32'(mm_y), 32'd0);
    endtask

    // Called just after a rising edge; leaves at the negedge of the first busy cycle.
    task automatic issue(input logic [K-1:0] b, input logic [K-1:0] e,
                         input logic [K-1:0] r, input int n);
        exp_t item;
        item.result = r;
        item.starts = n;
        exp_q.push_back(item);
        start  = 1'b1;
        base_i = b;
        exp_i  = e;
        @(negedge clk);
        check("result_held_until_accept", 32'(result), 32'(last_result));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait for done (bounded); returns just after the edge ending the done cycle.
    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < TIMEOUT && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_within_budget", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [K-1:0] b, input logic [K-1:0] e,
                          input logic [K-1:0] r, input int n);
        issue(b, e, r, n);
        wait_done();
        last_result = r;
    endtask

    initial begin
        bit got;
        rst    = 1'b1;
        start  = 1'b0;
        base_i = '0;
        exp_i  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // prompt multiplier
        run_op(8'd2, 8'd10,  8'd68, 13);
        run_op(8'd3, 8'd255, 8'd98, 19);
        run_op(8'd5, 8'd0,   8'd1,  11);
        run_op(8'd0, 8'd5,   8'd0,  13);

        // stale done held two extra cycles plus random latency
        hold_extra = 2;
        rand_lat   = 1'b1;
        run_op(8'd2, 8'd10,  8'd68,  13);
        run_op(8'd3, 8'd255, 8'd98,  19);
        run_op(8'd7, 8'd3,   8'd104, 13);

        // start re-pulsed while busy must be ignored
        issue(8'd2, 8'd10, 8'd68, 13);
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        base_i = 8'd5;
        exp_i  = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        last_result = 8'd68;

        // reset during the first square: operation abandoned, no done
        issue(8'd3, 8'd255, 8'd98, 19);
        got = 1'b0;
        for (int i = 0; i < TIMEOUT && !got; i++) begin
            @(negedge clk);
            if (start_cnt >= 3) got = 1'b1;
        end
        check("reached_square", 32'(got), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("in_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        last_result = '0;
        repeat (20) @(negedge clk);
        check_idle_outputs("after_reset");
        @(posedge clk);
        #1;

        // fresh operation, then a back-to-back request the cycle after done
        run_op(8'd2, 8'd10, 8'd68,  13);
        run_op(8'd7, 8'd3,  8'd104, 13);

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit in case the sequence stalls outside a bounded wait.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mod_exp_ctrl

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
- Montgomery modular-exponentiation sequencer for the RSA datapath. Computes result = base^exp mod M.
- Acts as the initiator for the team's bit-serial Montgomery multiplier, which computes z = x*y*2^-K mod M.
- Issues a sequence of multiply requests over the multiplier's start/done handshake.
- Presents a simple start/busy/done interface to the RSA top level.

Parameters:
- K, 192, operand width; the Montgomery radix is R = 2^K.
- LOGK, 8, width of the exponent bit-index counter; must satisfy 2^LOGK >= K.
- M, 192'hfffffffffffffffffffffffffffffffeffffffffffffffff, modulus; must be odd.
- R2_MOD_M, 192'h000000000000000100000000000000020000000000000001, R^2 mod M precomputed; must match M.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  K  base; captured on accepted start; must be < M.
- exp  in  K  exponent; captured on accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when result is valid.
- result  out  K  base^exp mod M; held from the done pulse until the next accept.
- mm_x  out  K  multiplier operand x; registered, stable from issue through completion.
- mm_y  out  K  multiplier operand y; same timing as mm_x.
- mm_start  out  1  one-cycle pulse requesting a multiply.
- mm_z  in  K  multiplier result; valid while mm_done is high.
- mm_done  in  1  multiplier done level. Remains high after completion until the multiplier accepts the next start.

Behaviour:
- Reset values: busy=0, done=0, result=0, mm_start=0, mm_x=0, mm_y=0. FSM goes to IDLE.
- Reset mid-operation: the operation is abandoned and no done is produced. Integration ties the multiplier's active-low reset to ~rst so both blocks restart together.
- Accept: start=1 in IDLE latches base and exp, sets the bit index to K-1, asserts busy next cycle. start while busy is ignored.
- Main FSM, one multiply per step:
  - CONV_B: mm_x=base, mm_y=R2_MOD_M. The result goes to bm (base in Montgomery form).
  - CONV_1: mm_x=1, mm_y=R2_MOD_M. The result goes to acc (equals R mod M).
  - SQR: mm_x=acc, mm_y=acc. The result goes to acc. Next state is MUL if exp[idx]=1; otherwise STEP.
  - MUL: mm_x=acc, mm_y=bm. The result goes to acc, then STEP.
  - STEP: if idx=0 go to CONV_OUT; otherwise decrement idx and go to SQR. Takes zero or one cycle, implementer's choice.
  - CONV_OUT: mm_x=acc, mm_y=1. The result goes to the result register, then FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Multiply sub-phase, used by every multiply state:
  - ISSUE: operands registered; mm_start=1 for exactly one cycle.
  - WAIT_LO: stay until mm_done=0. This discards the stale done level from the previous multiply; the multiplier drops done within 3 cycles of the start pulse.
  - WAIT_HI: on mm_done=1, capture mm_z and advance the main FSM.
  - mm_start is never asserted on two consecutive cycles.
  - Operands are never changed while in WAIT_LO or WAIT_HI.
- Multiply count per operation is exactly 3 + K + popcount(exp). All K exponent bits are processed MSB-first; no leading-zero skip.
- Boundaries:
  - exp=0 gives result 1.
  - base=0 with exp>0 gives result 0.
  - exp with all bits set is the worst case: 3+2K multiplies.
  - base >= M gives an undefined value, but the FSM must still terminate with done.
- All arithmetic is inside the multiplier; this block contains only muxes, registers and the LOGK-bit down-counter.

Decomposition:
- Shared package rsa_pkg:
  - K and LOGK.
  - Main state enum {IDLE, CONV_B, CONV_1, SQR, MUL, STEP, CONV_OUT, FINISH}.
  - Phase enum {ISSUE, WAIT_LO, WAIT_HI}.
- One natural sub-module: mm_req, the multiply-request handshake engine. Interface: go, x, y in; mm_* out; res and res_valid back to the main FSM.
- The multiplier itself is instantiated beside this block at the top level, not inside it.

Test Plan:
- All tests use K=8, M=239, R2_MOD_M=50, with the multiplier model attached.
- base=2, exp=10 → result=68; done exactly once; 13 mm_start pulses.
- base=3, exp=255 → result=98; 19 mm_start pulses; busy low on the cycle done is high.
- base=5, exp=0 → result=1; base=0, exp=5 → result=0.
- Multiplier model holds mm_done high 2 extra cycles after each start and adds random extra latency → results unchanged; no capture of stale mm_z.
- start re-pulsed while busy, and rst asserted mid-SQR → extra start ignored. After reset: all outputs 0. A fresh base=2, exp=10 then yields 68.
- Back-to-back requests: second start the cycle after done, base=7, exp=3 → result=104; result holds 68 until the accept.
